// File: rtl/cam_seq_pkg.sv
// -----------------------------------------------------------------------------
// cam_seq_pkg
// Shared types and constants for the camera power-up sequencer.
//   cam_seq_state_t : sequencer states
//   CAM_PWDN_*      : sensor PWDN pin levels (1 = powered down)
//   CAM_RST_*       : sensor RESET_N pin levels (active-low reset)
//   max3()          : largest of three values, used to size the tick counter
// -----------------------------------------------------------------------------
package cam_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PWDN   = 3'd1,
        RESET  = 3'd2,
        SETTLE = 3'd3,
        READY  = 3'd4,
        FAULT  = 3'd5
    } cam_seq_state_t;

    localparam logic CAM_PWDN_ON      = 1'b1;
    localparam logic CAM_PWDN_OFF     = 1'b0;
    localparam logic CAM_RST_ASSERT   = 1'b0;
    localparam logic CAM_RST_DEASSERT = 1'b1;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/cam_power_seq.sv
// -----------------------------------------------------------------------------
// cam_power_seq
// Camera power-up sequencer: walks the sensor through power-down, reset and
// settle phases, then raises ready_o to release the SCCB configuration stage.
// Phase lengths are counted in expirations ("ticks") of an external timer
// that this block drives through timer_count_o / timer_done_i.
//
// Ports:
//   clk_i          system clock
//   rst_i          asynchronous active-high reset
//   start_i        pulse, begin sequence (only from IDLE or FAULT)
//   stop_i         pulse, abort to IDLE from any state (wins over start_i)
//   timer_done_i   timer expiry
//   timer_count_o  timer enable; 0 reloads the timer
//   cam_pwdn_o     sensor power-down (1 = powered down)
//   cam_rst_n_o    sensor reset, active-low
//   busy_o         sequence in progress (PWDN/RESET/SETTLE)
//   ready_o        sequence complete
//   err_o          watchdog fault
//
// Optional feature: define CAM_SEQ_WDOG_EN to enable a watchdog that moves to
// FAULT when the timer fails to expire within wdog_cycles_g counting cycles.
// Without it FAULT is unreachable and err_o is tied 0.
// All outputs are registered (decoded from the next state).
// -----------------------------------------------------------------------------
module cam_power_seq
    import cam_seq_pkg::*;
#(
    parameter int unsigned pwdn_ticks_g   = 2,
    parameter int unsigned rst_ticks_g    = 3,
    parameter int unsigned settle_ticks_g = 5,
    parameter int unsigned wdog_cycles_g  = 4096
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic stop_i,
    input  logic timer_done_i,
    output logic timer_count_o,
    output logic cam_pwdn_o,
    output logic cam_rst_n_o,
    output logic busy_o,
    output logic ready_o,
    output logic err_o
);

    localparam int unsigned MaxTicks = max3(pwdn_ticks_g, rst_ticks_g, settle_ticks_g);
    localparam int unsigned TickW    = $clog2(MaxTicks + 1);

    cam_seq_state_t   r_state, w_state_nxt;
    logic [TickW-1:0] r_ticks, w_ticks_nxt;
    logic             r_count, w_count_nxt;
    logic             r_pwdn, w_pwdn_nxt;
    logic             r_rst_n, w_rst_n_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_ready, w_ready_nxt;

    logic w_tick;
    logic w_last_tick;
    logic w_enter;
    logic w_wdog_trip;

    // A tick only counts while we are actually enabling the timer.
    assign w_tick = r_count & timer_done_i;

    always_comb begin
        w_last_tick = 1'b0;
        case (r_state)
            PWDN:    w_last_tick = (r_ticks == TickW'(pwdn_ticks_g - 1));
            RESET:   w_last_tick = (r_ticks == TickW'(rst_ticks_g - 1));
            SETTLE:  w_last_tick = (r_ticks == TickW'(settle_ticks_g - 1));
            default: w_last_tick = 1'b0;
        endcase
    end

    // Next-state logic; a counted tick takes priority over a watchdog trip.
    always_comb begin
        w_state_nxt = r_state;
        if (stop_i) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: if (start_i) w_state_nxt = PWDN;
                PWDN: begin
                    if (w_tick && w_last_tick) w_state_nxt = RESET;
                    else if (w_wdog_trip)      w_state_nxt = FAULT;
                end
                RESET: begin
                    if (w_tick && w_last_tick) w_state_nxt = SETTLE;
                    else if (w_wdog_trip)      w_state_nxt = FAULT;
                end
                SETTLE: begin
                    if (w_tick && w_last_tick) w_state_nxt = READY;
                    else if (w_wdog_trip)      w_state_nxt = FAULT;
                end
                READY: w_state_nxt = READY;
                FAULT: if (start_i) w_state_nxt = PWDN;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign w_enter = (w_state_nxt != r_state);

    // Tick counter restarts on every state entry.
    always_comb begin
        w_ticks_nxt = r_ticks;
        if (w_enter)     w_ticks_nxt = '0;
        else if (w_tick) w_ticks_nxt = r_ticks + 1'b1;
    end

    // Output decode from the next state so every output is a plain register.
    always_comb begin
        w_pwdn_nxt  = CAM_PWDN_ON;
        w_rst_n_nxt = CAM_RST_ASSERT;
        w_busy_nxt  = 1'b0;
        w_ready_nxt = 1'b0;
        case (w_state_nxt)
            PWDN: begin
                w_busy_nxt = 1'b1;
            end
            RESET: begin
                w_pwdn_nxt = CAM_PWDN_OFF;
                w_busy_nxt = 1'b1;
            end
            SETTLE: begin
                w_pwdn_nxt  = CAM_PWDN_OFF;
                w_rst_n_nxt = CAM_RST_DEASSERT;
                w_busy_nxt  = 1'b1;
            end
            READY: begin
                w_pwdn_nxt  = CAM_PWDN_OFF;
                w_rst_n_nxt = CAM_RST_DEASSERT;
                w_ready_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    // Drop count for one cycle on phase entry and after each counted tick so
    // the timer reloads; this makes each tick exactly P+1 cycles.
    assign w_count_nxt = w_busy_nxt & ~w_enter & ~w_tick;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_ticks <= '0;
            r_count <= 1'b0;
            r_pwdn  <= CAM_PWDN_ON;
            r_rst_n <= CAM_RST_ASSERT;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ticks <= w_ticks_nxt;
            r_count <= w_count_nxt;
            r_pwdn  <= w_pwdn_nxt;
            r_rst_n <= w_rst_n_nxt;
            r_busy  <= w_busy_nxt;
            r_ready <= w_ready_nxt;
        end
    end

`ifdef CAM_SEQ_WDOG_EN
    localparam int unsigned WdogW = $clog2(wdog_cycles_g + 1);

    logic [WdogW-1:0] r_wdog, w_wdog_nxt;
    logic             r_err;

    // Trips on the cycle that would make the count reach wdog_cycles_g.
    assign w_wdog_trip = r_count & (r_wdog == WdogW'(wdog_cycles_g - 1));

    always_comb begin
        w_wdog_nxt = r_wdog;
        if (w_enter || w_tick || !r_count) w_wdog_nxt = '0;
        else                               w_wdog_nxt = r_wdog + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wdog <= '0;
            r_err  <= 1'b0;
        end else begin
            r_wdog <= w_wdog_nxt;
            r_err  <= (w_state_nxt == FAULT);
        end
    end

    assign err_o = r_err;
`else
    logic w_unused_wdog;
    assign w_unused_wdog = ^wdog_cycles_g;
    assign w_wdog_trip   = 1'b0;
    assign err_o         = 1'b0;
`endif

    assign timer_count_o = r_count;
    assign cam_pwdn_o    = r_pwdn;
    assign cam_rst_n_o   = r_rst_n;
    assign busy_o        = r_busy;
    assign ready_o       = r_ready;

endmodule

// File: tb/tb_cam_power_seq.sv
// -----------------------------------------------------------------------------
// tb_cam_power_seq
// Directed bench for cam_power_seq with a behavioural timer (P = 9, so one
// tick = 10 cycles). "Cycle n" is the interval after the n-th sampled edge;
// inputs change and outputs are sampled 1 ns after a rising edge.
// -----------------------------------------------------------------------------
module tb_cam_power_seq;

    localparam int unsigned P = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic tmr_en = 1'b1;

    logic timer_done;
    logic timer_count;
    logic cam_pwdn;
    logic cam_rst_n;
    logic busy;
    logic ready;
    logic err;

    logic [3:0] tmr_cnt;
    int tick_total;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    cam_power_seq #(
        .pwdn_ticks_g   (2),
        .rst_ticks_g    (3),
        .settle_ticks_g (5),
        .wdog_cycles_g  (16)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .stop_i        (stop),
        .timer_done_i  (timer_done),
        .timer_count_o (timer_count),
        .cam_pwdn_o    (cam_pwdn),
        .cam_rst_n_o   (cam_rst_n),
        .busy_o        (busy),
        .ready_o       (ready),
        .err_o         (err)
    );

    // Down-counting timer: reloads to P-1 while count is low, expires at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr_cnt <= 4'(P - 1);
        end else if (!timer_count || tmr_cnt == 4'd0) begin
            tmr_cnt <= 4'(P - 1);
        end else begin
            tmr_cnt <= tmr_cnt - 4'd1;
        end
    end

    assign timer_done = tmr_en && (tmr_cnt == 4'd0);

    always @(posedge clk) begin
        if (timer_count && timer_done) tick_total <= tick_total + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    initial begin
        int k;
        int t0;
        logic ok;

        // Reset state
        step();
        step();
        check_eq("rst_pwdn", cam_pwdn, 1);
        check_eq("rst_rst_n", cam_rst_n, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ready", ready, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_count", timer_count, 0);
        rst = 1'b0;
        step();
        step();

        // start and stop together in IDLE: stop wins
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        check_eq("startstop_busy", busy, 0);
        check_eq("startstop_pwdn", cam_pwdn, 1);
        step();
        check_eq("startstop_busy2", busy, 0);

        // Nominal sequence, with a stray start at k+5
        k = cyc;
        start = 1'b1;
        step();
        start = 1'b0;
        t0 = tick_total;
        check_eq("nom_busy_k1", busy, 1);
        check_eq("nom_count_k1", timer_count, 0);
        check_eq("nom_pwdn_k1", cam_pwdn, 1);
        check_eq("nom_rst_n_k1", cam_rst_n, 0);
        ok = 1'b1;
        for (int i = 2; i <= 10; i++) begin
            step();
            start = (cyc == k + 5);
            if (timer_count !== 1'b1) ok = 1'b0;
        end
        start = 1'b0;
        check_eq("nom_count_high_k2_k10", ok, 1);
        step();
        check_eq("nom_count_k11", timer_count, 0);
        run_to(k + 20);
        check_eq("nom_pwdn_k20", cam_pwdn, 1);
        step();
        check_eq("nom_pwdn_k21", cam_pwdn, 0);
        check_eq("nom_rst_n_k21", cam_rst_n, 0);
        check_eq("nom_busy_k21", busy, 1);
        run_to(k + 50);
        check_eq("nom_rst_n_k50", cam_rst_n, 0);
        step();
        check_eq("nom_rst_n_k51", cam_rst_n, 1);
        check_eq("nom_pwdn_k51", cam_pwdn, 0);
        run_to(k + 100);
        check_eq("nom_ready_k100", ready, 0);
        check_eq("nom_busy_k100", busy, 1);
        step();
        check_eq("nom_ready_k101", ready, 1);
        check_eq("nom_busy_k101", busy, 0);
        check_eq("nom_count_k101", timer_count, 0);
        check_eq("nom_pwdn_k101", cam_pwdn, 0);
        check_eq("nom_rst_n_k101", cam_rst_n, 1);
        check_eq("nom_tick_count", tick_total - t0, 10);
        run_to(k + 110);
        check_eq("nom_ready_hold", ready, 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_eq("stop_ready", ready, 0);
        check_eq("stop_pwdn", cam_pwdn, 1);
        check_eq("stop_rst_n", cam_rst_n, 0);
        step();

        // Abort in RESET phase, then restart
        k = cyc;
        start = 1'b1;
        step();
        start = 1'b0;
        run_to(k + 30);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_eq("abort_pwdn", cam_pwdn, 1);
        check_eq("abort_rst_n", cam_rst_n, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_count", timer_count, 0);
        run_to(k + 40);
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("restart_busy", busy, 1);
        run_to(k + 140);
        check_eq("restart_ready_k140", ready, 0);
        step();
        check_eq("restart_ready_k141", ready, 1);
        stop = 1'b1;
        step();
        stop = 1'b0;

        // Asynchronous reset mid-SETTLE, start held during reset
        k = cyc;
        start = 1'b1;
        step();
        start = 1'b0;
        run_to(k + 60);
        #3;
        rst   = 1'b1;
        start = 1'b1;
        #1;
        check_eq("arst_pwdn", cam_pwdn, 1);
        check_eq("arst_rst_n", cam_rst_n, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_count", timer_count, 0);
        step();
        step();
        check_eq("arst_start_ignored", busy, 0);
        start = 1'b0;
        rst   = 1'b0;
        step();
        check_eq("arst_release_busy", busy, 0);
        check_eq("arst_release_pwdn", cam_pwdn, 1);

        // Timer never expires
        tmr_en = 1'b0;
        k = cyc;
        start = 1'b1;
        step();
        start = 1'b0;
`ifdef CAM_SEQ_WDOG_EN
        run_to(k + 17);
        check_eq("wdog_err_k17", err, 0);
        check_eq("wdog_busy_k17", busy, 1);
        step();
        check_eq("wdog_err_k18", err, 1);
        check_eq("wdog_pwdn_k18", cam_pwdn, 1);
        check_eq("wdog_rst_n_k18", cam_rst_n, 0);
        check_eq("wdog_busy_k18", busy, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("wdog_restart_err", err, 0);
        check_eq("wdog_restart_busy", busy, 1);
`else
        run_to(k + 60);
        check_eq("nowdog_err", err, 0);
        check_eq("nowdog_busy", busy, 1);
        check_eq("nowdog_pwdn", cam_pwdn, 1);
`endif
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_eq("final_idle_busy", busy, 0);
        tmr_en = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cam_power_seq.md
Name: cam_power_seq

Overview:
- Camera power-up sequencer. Drives the sensor PWDN and RESET_N pins through a fixed power-down → reset → settle sequence, then signals the configuration stage.
- It is the controlling stage of the shared `timer` block: it drives the timer's `count_i` and consumes its `done_o`.
- Each phase length is expressed in timer expirations ("ticks").
- `ready_o` gates the downstream SCCB register-configuration stage.

Parameters:
- pwdn_ticks_g, 2: ticks spent in PWDN phase. Must be ≥1.
- rst_ticks_g, 3: ticks spent in RESET phase. Must be ≥1.
- settle_ticks_g, 5: ticks spent in SETTLE phase. Must be ≥1.
- wdog_cycles_g, 4096: watchdog limit in clock cycles. Used only with CAM_SEQ_WDOG_EN.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  pulse; begin the sequence (honoured only in IDLE or FAULT)
- stop_i  in  1  pulse; abort to IDLE from any state
- timer_done_i  in  1  from timer `done_o`
- timer_count_o  out  1  to timer `count_i`
- cam_pwdn_o  out  1  sensor power-down, 1 = powered down
- cam_rst_n_o  out  1  sensor reset, active-low
- busy_o  out  1  sequence in progress (PWDN, RESET or SETTLE)
- ready_o  out  1  sequence complete; sensor may be configured
- err_o  out  1  watchdog fault; tied 0 when CAM_SEQ_WDOG_EN is undefined

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE, timer_count_o=0, cam_pwdn_o=1, cam_rst_n_o=0, busy_o=0, ready_o=0, err_o=0, tick counter=0.
  - Reset takes effect immediately, including mid-sequence.
- All outputs are registered.
- Pin and status levels per state:
  - IDLE: pwdn=1, rst_n=0, busy=0, ready=0.
  - PWDN: pwdn=1, rst_n=0, busy=1.
  - RESET: pwdn=0, rst_n=0, busy=1.
  - SETTLE: pwdn=0, rst_n=1, busy=1.
  - READY: pwdn=0, rst_n=1, ready=1; holds until stop_i or reset.
  - FAULT: pwdn=1, rst_n=0, err=1.
- Transitions:
  - IDLE → PWDN on start_i.
  - PWDN → RESET after pwdn_ticks_g ticks.
  - RESET → SETTLE after rst_ticks_g ticks.
  - SETTLE → READY after settle_ticks_g ticks.
- Tick handshake (the timer reloads while count_i=0 and asserts done_o when its counter is 0):
  - timer_count_o=0 in the first cycle of each active phase and in the cycle after each sampled timer_done_i; otherwise 1 in active phases.
  - timer_count_o=0 in IDLE, READY and FAULT.
  - A tick is counted only when timer_done_i=1 and timer_count_o=1.
  - Tick period = P+1 cycles, where P is the timer's clk_periods_g. Phase length = ticks × (P+1) cycles exactly.
- Tick counter:
  - Width = $clog2(max tick parameter + 1).
  - Cleared on every state entry; no wrap-around possible.
  - On the final tick of a phase, the state changes in the next cycle.
- stop_i: from any state → IDLE next cycle, tick counter cleared, err_o cleared.
- start_i and stop_i in the same cycle: stop_i wins.
- start_i outside IDLE/FAULT: ignored.
- stop_i in IDLE: no effect.
- timer_done_i while timer_count_o=0: ignored.

Optional Feature:
- CAM_SEQ_WDOG_EN defined:
  - A cycle counter runs while timer_count_o=1. It clears on each counted tick and on state entry.
  - If it reaches wdog_cycles_g, the next state is FAULT (err_o=1, pins in safe levels).
  - FAULT is left only by start_i (→ PWDN, err_o cleared), stop_i (→ IDLE) or reset.
- CAM_SEQ_WDOG_EN undefined: no watchdog counter, FAULT is unreachable, err_o tied 0.

Decomposition:
- cam_seq_pkg contains:
  - typedef enum cam_seq_state_t {IDLE, PWDN, RESET, SETTLE, READY, FAULT};
  - pin-level constants CAM_PWDN_ON/OFF and CAM_RST_ASSERT/DEASSERT.
- No sub-module. `timer` is instantiated by the parent alongside this block, with count_o/done_i wired point-to-point.

Test Plan:
- Common setup: timer with P=9, default tick parameters, start_i pulsed at cycle k.
- Nominal sequence: busy_o rises at k+1; RESET phase (pwdn=0) begins at k+21; SETTLE (rst_n=1) begins at k+51; ready_o=1 and busy_o=0 at k+101.
- Tick handshake: check timer_count_o=0 at k+1 and k+11, and 1 at k+2..k+10; exactly 10 counted ticks before ready_o.
- Abort: stop_i at k+30 → cycle k+31 shows IDLE levels (pwdn=1, rst_n=0, busy=0). Fresh start_i at k+40 → ready_o at k+141.
- Async reset mid-operation: rst_i asserted at k+60 off-edge → outputs take reset values before the next edge. start_i is ignored while rst_i=1.
- Same-cycle start/stop and start while busy: start_i with stop_i in IDLE → stays IDLE. start_i at k+5 → no timing change.
- Watchdog (CAM_SEQ_WDOG_EN, wdog_cycles_g=16, timer_done_i tied 0): err_o=1 and cam_pwdn_o=1 at k+18. start_i clears err_o and re-enters PWDN.
